fp_mul_result_stage: RTL and testbench
======================================

// Module: fp_mul_result_stage
// PURPOSE
//  Registered output stage directly downstream of the combinational single-precision multiplier.
//  - Takes the operand pair and the raw product word from the multiplier in the same cycle.
//  - Applies IEEE-754 special-case and range overrides, then raises exception flags.
//  - Buffers results in a small FIFO with valid/ready handshakes on both sides.
//  - Isolates the multiplier's long combinational path from downstream consumers.
// PARAMETERS
//  DEPTH   2   result FIFO entries; power of two, >= 2
//  CNT_W   2   width of o_count; equals clog2(DEPTH)+1
// PORTS
//  i_clk        in   1   clock; all state updates on its rising edge
//  i_rst        in   1   reset, synchronous, active-high
//  i_valid      in   1   operand pair and raw product valid
//  o_ready      out  1   stage can accept; equals !full, with no combinational path from i_ready
//  i_mul_one    in   32  operand A (IEEE single precision)
//  i_mul_two    in   32  operand B (IEEE single precision)
//  i_mul        in   32  raw product from the multiplier for the same A and B
//  o_valid      out  1   FIFO head valid; equals !empty
//  i_ready      in   1   downstream accepts the head entry
//  o_result     out  32  head result word
//  o_flags      out  4   head flags {invalid, overflow, underflow, zero}
//  o_count      out  CNT_W  current occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (sync, i_rst=1 at edge):
//   - Read pointer, write pointer and count go to 0.
//   - o_valid=0, o_ready=1, o_count=0, o_result=32'h0, o_flags=4'h0.
//   - Reset asserted mid-stream discards all buffered entries; the cycle with i_rst=1 accepts nothing.
//  Handshake:
//   - Push when i_valid && o_ready; pop when o_valid && i_ready.
//   - Push and pop in the same cycle leave the count unchanged; both pointers advance.
//   - At full, o_ready=0, so a push is impossible; a pop alone drops the count.
//   - At empty, pop is impossible; a push alone raises the count.
//   - Pointers wrap modulo DEPTH.
//   - o_result and o_flags are stable while o_valid && !i_ready.
//  Latency:
//   - Operands accepted at edge N into an empty FIFO give o_valid=1 after edge N, visible during cycle N+1.
//   - Order is strictly FIFO.
//  Classification (combinational, before the FIFO write):
//   - ea, eb = exponent fields; fa, fb = fraction fields; s = sign(A) ^ sign(B).
//   - NaN = e==8'hFF && f!=0. INF = e==8'hFF && f==0. ZERO = e==0; denormals are flushed to zero.
//  Override priority, first match wins:
//   1. A or B is NaN, or (INF and ZERO together):
//      result 32'h7FC00000, flags 4'b1000.
//   2. A or B is INF:
//      result {s,8'hFF,23'h0}, flags 4'b0000.
//   3. A or B is ZERO:
//      result {s,31'h0}, flags 4'b0001.
//   4. esum = ea + eb - 127, computed as a 10-bit signed value. If esum > 254 or i_mul[30:23]==8'hFF:
//      result {s,8'hFF,23'h0}, flags 4'b0100.
//   5. esum < 1:
//      result {s,31'h0}, flags 4'b0011.
//   6. Otherwise:
//      result {s,i_mul[30:0]}; flags zero bit = (i_mul[30:0]==0), all other flags 0.
//  Arithmetic:
//   - esum uses 10-bit arithmetic, so no wrap occurs for any 8-bit exponent pair.
// TESTING
//  1. 2.0 (40000000) x 3.0 (40400000), i_mul=40C00000, i_ready=1:
//     o_valid=1 next cycle, o_result=40C00000, o_flags=0.
//  2. 7F800000 x 00000000:
//     o_result=7FC00000, o_flags=4'b1000.
//     Also FF800000 x 3F800000 gives FF800000, o_flags=0.
//  3. 7F000000 x 7F000000 (esum=381):
//     o_result=7F800000, o_flags=4'b0100.
//     Also 00800000 x 00800000 gives 00000000, o_flags=4'b0011.
//  4. i_ready=0 with 3 pushes attempted, DEPTH=2:
//     o_count=2, o_ready=0, third operand held upstream.
//     Then i_ready=1 drains in order with no loss.
//  5. At o_count=1, push and pop in the same cycle:
//     o_count stays 1, both pointers wrap correctly over 4 consecutive cycles.
//  6. i_rst=1 asserted while o_count=2:
//     next cycle o_valid=0, o_count=0, o_ready=1; old results never reappear.

Source files
------------

// File: rtl/fp_mul_result_stage.sv
// ----------------------------------------------------------------------------
// fp_mul_result_stage
//
// Registered output stage that sits directly after a combinational IEEE-754
// single-precision multiplier. Each cycle it can take an operand pair together
// with the multiplier's raw product. It then applies the special-case and
// exponent-range overrides, works out the exception flags, and stores the
// final word in a small result FIFO. Valid/ready handshakes are used on both
// sides. Every output comes from a register or from FIFO storage, so the long
// multiplier path ends here.
//
// Parameters
//   DEPTH      result FIFO entries; a power of two, at least 2
//   CNT_W      width of o_count; clog2(DEPTH)+1
//
// Ports
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset
//   i_valid    operand pair and raw product are valid
//   o_ready    stage can accept (FIFO not full); registered, independent of i_ready
//   i_mul_one  operand A
//   i_mul_two  operand B
//   i_mul      raw product of A and B from the multiplier
//   o_valid    FIFO head valid (FIFO not empty)
//   i_ready    downstream accepts the head entry
//   o_result   head result word (zero while empty)
//   o_flags    head flags {invalid, overflow, underflow, zero}
//   o_count    current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module fp_mul_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_mul_one,
    input  logic [31:0]      i_mul_two,
    input  logic [31:0]      i_mul,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_result,
    output logic [3:0]       o_flags,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;   // {invalid, overflow, underflow, zero}
    } entry_t;

    // ------------------------------------------------------------------
    // Operand classification
    // ------------------------------------------------------------------
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        s;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic        nan_any, inf_any, zero_any;
    logic signed [9:0] esum;

    // The product sign is rebuilt from the operand signs, so the sign bit of
    // the raw product is not needed.
    logic        mul_sign_unused;
    assign mul_sign_unused = i_mul[31];

    assign ea = i_mul_one[30:23];
    assign eb = i_mul_two[30:23];
    assign fa = i_mul_one[22:0];
    assign fb = i_mul_two[22:0];
    assign s  = i_mul_one[31] ^ i_mul_two[31];

    assign nan_a  = (ea == 8'hFF) && (fa != 23'd0);
    assign nan_b  = (eb == 8'hFF) && (fb != 23'd0);
    assign inf_a  = (ea == 8'hFF) && (fa == 23'd0);
    assign inf_b  = (eb == 8'hFF) && (fb == 23'd0);
    // A zero exponent is treated as zero, so denormal inputs are flushed.
    assign zero_a = (ea == 8'd0);
    assign zero_b = (eb == 8'd0);

    assign nan_any  = nan_a  | nan_b;
    assign inf_any  = inf_a  | inf_b;
    assign zero_any = zero_a | zero_b;

    // Ten bits cover 0+0-127 = -127 up to 255+255-127 = 383 without wrapping.
    assign esum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

    // ------------------------------------------------------------------
    // Override priority (first match wins)
    // ------------------------------------------------------------------
    entry_t wr_entry;

    always_comb begin
        // NOTE: every signal written here gets a default first, so a missed
        // branch can never infer a latch.
        wr_entry.result = {s, i_mul[30:0]};
        wr_entry.flags  = {3'b000, (i_mul[30:0] == 31'd0)};

        if (nan_any || (inf_any && zero_any)) begin
            wr_entry.result = 32'h7FC0_0000;
            wr_entry.flags  = 4'b1000;
        end else if (inf_any) begin
            wr_entry.result = {s, 8'hFF, 23'd0};
            wr_entry.flags  = 4'b0000;
        end else if (zero_any) begin
            wr_entry.result = {s, 31'd0};
            wr_entry.flags  = 4'b0001;
        end else if ((esum > 10'sd254) || (i_mul[30:23] == 8'hFF)) begin
            wr_entry.result = {s, 8'hFF, 23'd0};
            wr_entry.flags  = 4'b0100;
        end else if (esum < 10'sd1) begin
            wr_entry.result = {s, 31'd0};
            wr_entry.flags  = 4'b0011;
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, empty, push, pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    // Both handshakes depend only on registered occupancy, so there is no
    // combinational path from i_ready to o_ready.
    assign push  = i_valid && !full;
    assign pop   = !empty && i_ready;

    // NOTE: the storage array has no reset. An entry is only visible when
    // count covers it, and the head output is gated to zero while empty, so
    // stale contents cannot leak out after a reset.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples pre-edge values regardless of statement order.
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign o_ready  = !full;
    assign o_valid  = !empty;
    assign o_count  = count;
    // The head word only changes on a pop, so it holds steady while stalled.
    assign o_result = empty ? 32'h0 : mem[rd_ptr].result;
    assign o_flags  = empty ? 4'h0  : mem[rd_ptr].flags;

endmodule

// File: tb/tb_fp_mul_result_stage.sv
// ----------------------------------------------------------------------------
// tb_fp_mul_result_stage
//
// Scoreboard bench for fp_mul_result_stage (DEPTH=2). The stimulus tasks push
// the hand-computed expected word and flags into a queue when the stage
// accepts an operand pair. A separate monitor pops the queue and compares it
// with the DUT whenever a head entry is handed downstream. All inputs change
// 1 time unit after a rising edge. Outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_fp_mul_result_stage;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_mul_one;
    logic [31:0] i_mul_two;
    logic [31:0] i_mul;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic [3:0]  o_flags;
    logic [1:0]  o_count;

    fp_mul_result_stage #(.DEPTH(2), .CNT_W(2)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_mul_one (i_mul_one),
        .i_mul_two (i_mul_two),
        .i_mul     (i_mul),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_result  (o_result),
        .o_flags   (o_flags),
        .o_count   (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next rising edge exactly when these hold now.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got result=%h flags=%b, required no output",
                         o_result, o_flags);
            end else begin
                mon_e = sb_q.pop_front();
                if (o_result !== mon_e.res || o_flags !== mon_e.flg) begin
                    n_bad++;
                    $display("FAIL head_entry: got result=%h flags=%b, required result=%h flags=%b",
                             o_result, o_flags, mon_e.res, mon_e.flg);
                end
            end
        end
    end

    // Present one operand pair and hold it until accepted (bounded wait).
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] m,
                        input logic [31:0] er, input logic [3:0] ef);
        int   n;
        exp_t e;
        n         = 0;
        i_valid   = 1'b1;
        i_mul_one = a;
        i_mul_two = b;
        i_mul     = m;
        e.res     = er;
        e.flg     = ef;
        forever begin
            @(negedge i_clk);
            if (o_ready) begin
                sb_q.push_back(e);
                break;
            end
            n++;
            if (n > 200) begin
                check("send_accept_timeout", 32'(o_ready), 32'd1);
                break;
            end
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
        @(posedge i_clk); #1;
        check("drain_count", 32'(o_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_rst     = 1'b1;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_mul_one = '0;
        i_mul_two = '0;
        i_mul     = '0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        // Reset state
        check("rst_valid",  32'(o_valid),  32'd0);
        check("rst_ready",  32'(o_ready),  32'd1);
        check("rst_count",  32'(o_count),  32'd0);
        check("rst_result", o_result,      32'h0);
        check("rst_flags",  32'(o_flags),  32'h0);

        // Single-cycle latency into an empty FIFO
        i_ready = 1'b1;
        send(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 32'h40C0_0000, 4'b0000);
        check("lat_valid", 32'(o_valid), 32'd1);
        check("lat_count", 32'(o_count), 32'd1);

        // Override classes and exponent boundaries, streamed back to back
        send(32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000); // INF x 0
        send(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000, 4'b0000); // -INF x 1
        send(32'h7F00_0000, 32'h7F00_0000, 32'h1234_5678, 32'h7F80_0000, 4'b0100); // esum 381
        send(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 32'h0000_0000, 4'b0011); // esum -125
        send(32'h7FC0_0001, 32'h3F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000); // qNaN
        send(32'h7F80_0001, 32'hBF80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000); // sNaN
        send(32'h8000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h8000_0000, 4'b0001); // -0 x 1
        send(32'h0000_0001, 32'hC000_0000, 32'h0000_0000, 32'h8000_0000, 4'b0001); // denormal
        send(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 32'hC0C0_0000, 4'b0000); // -2 x 3
        send(32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000, 4'b0100); // product exp FF
        send(32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 32'h7F00_0000, 4'b0000); // esum 254
        send(32'h7F00_0000, 32'h4000_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100); // esum 255
        send(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 32'h0080_0000, 4'b0000); // esum 1
        send(32'h0080_0000, 32'h3F00_0000, 32'h0040_0000, 32'h0000_0000, 4'b0011); // esum 0
        send(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h8000_0000, 4'b0001); // zero magnitude
        send(32'hFF80_0000, 32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000); // -INF x -0
        send(32'h7FFF_FFFF, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000); // NaN x INF
        wait_drain();

        // Back-pressure: fill to DEPTH, third pair held upstream, then drain in order
        i_ready = 1'b0;
        send(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 32'h4080_0000, 4'b0000);
        send(32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 32'h4110_0000, 4'b0000);
        check("full_count", 32'(o_count), 32'd2);
        check("full_ready", 32'(o_ready), 32'd0);
        fork
            send(32'h4080_0000, 32'h4080_0000, 32'h4180_0000, 32'h4180_0000, 4'b0000);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(posedge i_clk); #1;
                    check("stall_count",  32'(o_count), 32'd2);
                    check("stall_ready",  32'(o_ready), 32'd0);
                    check("stall_result", o_result,     32'h4080_0000);
                end
                i_ready = 1'b1;
            end
        join
        wait_drain();

        // Simultaneous push and pop at count 1, over enough cycles to wrap pointers
        i_ready = 1'b0;
        send(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 4'b0000);
        check("pp_start_count", 32'(o_count), 32'd1);
        i_ready = 1'b1;
        send(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 32'h4080_0000, 4'b0000);
        check("pp_count_1", 32'(o_count), 32'd1);
        send(32'hC000_0000, 32'h4000_0000, 32'hC080_0000, 32'hC080_0000, 4'b0000);
        check("pp_count_2", 32'(o_count), 32'd1);
        send(32'h7F80_0000, 32'h4000_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0000);
        check("pp_count_3", 32'(o_count), 32'd1);
        send(32'h3F00_0000, 32'h3F00_0000, 32'h3E80_0000, 32'h3E80_0000, 4'b0000);
        check("pp_count_4", 32'(o_count), 32'd1);
        wait_drain();

        // Reset with two entries buffered; the reset cycle also offers a push
        i_ready = 1'b0;
        send(32'h4100_0000, 32'h4000_0000, 32'h4180_0000, 32'h4180_0000, 4'b0000);
        send(32'h4110_0000, 32'h4000_0000, 32'h4190_0000, 32'h4190_0000, 4'b0000);
        check("prerst_count", 32'(o_count), 32'd2);
        i_rst     = 1'b1;
        i_ready   = 1'b1;
        i_valid   = 1'b1;
        i_mul_one = 32'h4000_0000;
        i_mul_two = 32'h4000_0000;
        i_mul     = 32'h4080_0000;
        sb_q.delete();
        @(posedge i_clk); #1;
        i_rst   = 1'b0;
        i_valid = 1'b0;
        check("midrst_valid",  32'(o_valid), 32'd0);
        check("midrst_count",  32'(o_count), 32'd0);
        check("midrst_ready",  32'(o_ready), 32'd1);
        check("midrst_result", o_result,     32'h0);
        repeat (3) @(posedge i_clk);
        #1;
        check("postrst_idle_valid", 32'(o_valid), 32'd0);
        send(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 32'h40C0_0000, 4'b0000);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
